// File: rtl/seven_seg_scanner_if.sv
// Bundle between the seven-segment scanner and its host: load request side plus display drive.
interface seven_seg_scanner_if;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        lzb;
  logic        load;
  logic        load_ack;
  logic [3:0]  nibble;
  logic        blank;
  logic [7:0]  an;
  logic        dp;
  logic        frame_done;

  modport master (
    output value, dp_in, digit_en, lzb, load,
    input  load_ack, nibble, blank, an, dp, frame_done
  );

  modport slave (
    input  value, dp_in, digit_en, lzb, load,
    output load_ack, nibble, blank, an, dp, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with per-digit blanking gap, shadowed
// display data captured only at frame boundaries, and optional leading-zero blanking.
module seven_seg_scanner #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input logic               clk,
  input logic               reset,
  seven_seg_scanner_if.slave bus
);

  localparam int unsigned CntMax = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int unsigned CW     = (CntMax < 2) ? 1 : $clog2(CntMax);

  typedef enum logic {StBlank, StDrive} state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [31:0]   shadow_value;
  logic [7:0]    shadow_dp;
  logic [7:0]    shadow_en;
  logic          lzb_q;
  logic          load_ack_q;

  logic boundary;
  logic upper_zero;
  logic suppressed;
  logic lit;

  assign boundary = (state == StDrive) && (idx == 3'd7) && (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StBlank;
      idx          <= 3'd0;
      cnt          <= '0;
      shadow_value <= 32'h0;
      shadow_dp    <= 8'h00;
      shadow_en    <= 8'hFF;
      lzb_q        <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      // lzb is registered so no input reaches an output combinationally.
      lzb_q      <= bus.lzb;
      load_ack_q <= 1'b0;
      unique case (state)
        StBlank: begin
          if (cnt == CW'(BLANK_CYC - 1)) begin
            state <= StDrive;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StDrive: begin
          if (cnt == CW'(TICK_DIV - 1)) begin
            state <= StBlank;
            cnt   <= '0;
            idx   <= idx + 3'd1;
            // Capture edge is the frame boundary; the ack is visible right after that edge.
            if (boundary && bus.load) begin
              shadow_value <= bus.value;
              shadow_dp    <= bus.dp_in;
              shadow_en    <= bus.digit_en;
              load_ack_q   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= StBlank;
      endcase
    end
  end

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(idx) && shadow_value[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign suppressed = !shadow_en[idx] || (lzb_q && (idx != 3'd0) && upper_zero);
  assign lit        = (state == StDrive) && !suppressed;

  assign bus.nibble     = shadow_value[{idx, 2'b00} +: 4];
  assign bus.an         = lit ? ~(8'h01 << idx) : 8'hFF;
  assign bus.blank      = !lit;
  assign bus.dp         = lit ? ~shadow_dp[idx] : 1'b1;
  assign bus.frame_done = boundary;
  assign bus.load_ack   = load_ack_q;

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter TICK_DIV, default 50000: clock cycles each digit is driven; legal range >= 2.
REQ-002 Parameter BLANK_CYC, default 4: clock cycles with all anodes off before each digit is driven; legal range >= 1.
REQ-003 clk  in  1  single system clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 value  in  32  eight hex nibbles; digit i = value[4i+3:4i].
REQ-006 dp_in  in  8  decimal-point request per digit, 1 = lit.
REQ-007 digit_en  in  8  per-digit enable, 1 = digit may light.
REQ-008 lzb  in  1  leading-zero blanking enable.
REQ-009 load  in  1  level request to capture value, dp_in and digit_en.
REQ-010 load_ack  out  1  one-cycle pulse; inputs were captured this cycle.
REQ-011 nibble  out  4  hex code of the current digit, fed to the shared hex-to-7-segment decoder.
REQ-012 blank  out  1  1 = segments must be forced off downstream.
REQ-013 an  out  8  anode selects, active-low, at most one bit low.
REQ-014 dp  out  1  decimal point, active-low.
REQ-015 frame_done  out  1  one-cycle pulse at the end of digit 7.

Function
REQ-016 Shadow registers SHALL hold value, dp_in and digit_en; all display outputs SHALL derive from the shadows only, never from the live inputs.
REQ-017 The FSM SHALL have two states, BLANK and DRIVE, plus a 3-bit digit index idx.
REQ-018 BLANK: an = 8'hFF, blank = 1, dp = 1; after exactly BLANK_CYC cycles -> DRIVE.
REQ-019 DRIVE: a prescaler counts 0..TICK_DIV-1; on the cycle it equals TICK_DIV-1 -> BLANK, prescaler cleared, idx increments modulo 8.
REQ-020 Digit period SHALL be BLANK_CYC + TICK_DIV cycles; full frame = 8 periods.
REQ-021 nibble SHALL equal shadow_value[4*idx+3:4*idx] in both states.
REQ-022 A digit is suppressed when shadow_en[idx] = 0, or when lzb = 1, idx > 0 and nibbles idx..7 of shadow_value are all zero; digit 0 is never zero-suppressed.
REQ-023 In DRIVE with the digit not suppressed: an[idx] = 0 and all other an bits = 1, blank = 0, dp = ~shadow_dp[idx].
REQ-024 In DRIVE with the digit suppressed: an = 8'hFF, blank = 1, dp = 1.
REQ-025 Frame boundary = the DRIVE->BLANK transition cycle with idx = 7; frame_done SHALL pulse on that cycle.
REQ-026 If load = 1 on a frame-boundary cycle, the shadows SHALL capture the inputs on that edge and load_ack SHALL pulse on the same cycle.
REQ-027 load asserted at any other time SHALL wait for the next boundary; the requester holds its inputs stable until load_ack.
REQ-028 load held high across several boundaries SHALL capture and acknowledge at each boundary.
REQ-029 All outputs SHALL be registered or decoded from registered state only; the block has no combinational path from input to output.

Reset
REQ-030 While reset = 1, outputs SHALL take these values immediately, independent of clk: an = 8'hFF, dp = 1, blank = 1, nibble = 0, load_ack = 0, frame_done = 0.
REQ-031 Reset SHALL set the state to BLANK, idx = 0, both counters = 0, shadow_value = 0, shadow_dp = 0 and shadow_en = 8'hFF.
REQ-032 Reset asserted mid-frame SHALL abort the current digit; after release, scanning restarts at idx 0 in BLANK.

Verification (TICK_DIV = 4, BLANK_CYC = 2, period = 6 cycles)
REQ-033 Release reset, then load 32'h000000A5 with digit_en = 8'hFF and lzb = 0. Required: after the boundary, an steps FE, FD, FB, ... 7F; each value lasts 4 cycles and is separated by 2 cycles of FF; nibble = 5, A, then 0.
REQ-034 lzb = 1 with 32'h000000A5. Required: only an = FE and FD ever go low. With value = 0: only digit 0 lights, and nibble = 0.
REQ-035 load raised mid-frame at idx 3. Required: load_ack is delayed to the idx-7 boundary and the display is unchanged before it. With load raised exactly on the boundary cycle: ack on that same cycle.
REQ-036 digit_en = 8'h0F. Required: an[7:4] stay 1 for the whole frame; blank = 1 during idx 4..7.
REQ-037 dp_in = 8'h02. Required: dp = 0 only in DRIVE with idx = 1.
REQ-038 reset pulsed in DRIVE at idx 5. Required: an = FF asynchronously; after release, the first lit anode is FE, 2 cycles later.
